// File: rtl/fetch_decode_stage.sv
// Decode stage behind the instruction fetcher: selects one RV64I instruction from the fetched
// cache word, decodes its fields and immediate, and registers the result for execute.
module fetch_decode_stage #(
  parameter int ADDR_W = 64,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetcher_done,
  input  logic [WORD_W-1:0] instruction_in,
  input  logic [ADDR_W-1:0] address_in,
  output logic              fetch_ack,
  input  logic              flush,
  input  logic              decode_ready,
  output logic              decode_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_out,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        funct7,
  output logic [ADDR_W-1:0] imm,
  output logic              illegal
);

  typedef enum logic {IDLE, VALID} state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t            state, state_next;
  logic              capture;
  logic              load;
  logic [31:0]       instr_sel;
  logic [ADDR_W-1:0] imm_dec;
  logic              illegal_dec;

  assign instr_sel = address_in[2] ? instruction_in[63:32] : instruction_in[31:0];

  // The ack cycle blocks a second capture while the fetcher still holds fetcher_done.
  assign capture = fetcher_done && !fetch_ack && (state == IDLE || decode_ready);
  assign load    = capture && !flush;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    imm_dec     = '0;
    illegal_dec = 1'b0;
    unique case (instr_sel[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
        imm_dec = {{(ADDR_W-12){instr_sel[31]}}, instr_sel[31:20]};
      OP_STORE:
        imm_dec = {{(ADDR_W-12){instr_sel[31]}}, instr_sel[31:25], instr_sel[11:7]};
      OP_BRANCH:
        imm_dec = {{(ADDR_W-13){instr_sel[31]}}, instr_sel[31], instr_sel[7],
                   instr_sel[30:25], instr_sel[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_dec = {{(ADDR_W-32){instr_sel[31]}}, instr_sel[31:12], 12'b0};
      OP_JAL:
        imm_dec = {{(ADDR_W-21){instr_sel[31]}}, instr_sel[31], instr_sel[19:12],
                   instr_sel[20], instr_sel[30:21], 1'b0};
      OP_REG, OP_REG32, OP_FENCE:
        imm_dec = '0;
      default:
        illegal_dec = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (capture) state_next = VALID;
        VALID:   if (decode_ready) state_next = capture ? VALID : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_ack <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_ack <= capture;
    end
  end

  // NOTE: the output data registers are reset too, because downstream sees zeros out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out    <= '0;
      instr_out <= '0;
      imm       <= '0;
      illegal   <= 1'b0;
    end else if (load) begin
      pc_out    <= address_in;
      instr_out <= instr_sel;
      imm       <= imm_dec;
      illegal   <= illegal_dec;
    end
  end

  assign decode_valid = (state == VALID);
  assign opcode       = instr_out[6:0];
  assign rd           = instr_out[11:7];
  assign funct3       = instr_out[14:12];
  assign rs1          = instr_out[19:15];
  assign rs2          = instr_out[24:20];
  assign funct7       = instr_out[31:25];

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Decode stage sitting directly downstream of the instruction fetcher.
- Consumes the fetcher's 64-bit cache word and fetch address through the fetcher_done/fetch_ack handshake.
- Selects the 32-bit RV64I instruction, decodes its fields and sign-extended immediate, and holds them in an output register.
- Presents the result to the execute stage with a valid/ready handshake; supports flush on branch redirect.

Parameters:
ADDR_W, 64, width of PC/address and of the immediate output
WORD_W, 64, width of the fetched cache word (two 32-bit instructions)

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  one clock; reset is asynchronous and active-low
fetcher_done  in  1  fetcher holds valid instruction_in/address_in
instruction_in  in  WORD_W  fetched cache word
address_in  in  ADDR_W  fetch address of the instruction
fetch_ack  out  1  one-cycle pulse acknowledging capture
flush  in  1  discard held/incoming instruction (branch redirect)
decode_ready  in  1  execute stage accepts the current output
decode_valid  out  1  decoded outputs are valid
pc_out  out  ADDR_W  address of decoded instruction
instr_out  out  32  selected raw instruction
opcode  out  7  instr[6:0]
rd  out  5  instr[11:7]
funct3  out  3  instr[14:12]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
funct7  out  7  instr[31:25]
imm  out  ADDR_W  sign-extended immediate
illegal  out  1  opcode not a supported RV64I opcode

Behaviour:
- Reset (reset=0, async): state IDLE; fetch_ack=0, decode_valid=0, illegal=0; every data output is 0.
- Instruction select: address_in[2]=0 selects instruction_in[31:0]; address_in[2]=1 selects instruction_in[63:32].
- Decode is combinational on the selected word and is registered at capture. Latency is 1 cycle, from the fetcher_done sample edge to decode_valid=1.
- Capture condition: fetcher_done=1 AND fetch_ack=0 AND (state IDLE, or state VALID with decode_ready=1).
  - fetch_ack is registered and is 1 for exactly the cycle after capture.
  - fetcher_done may still be 1 during that ack cycle. It must not cause a second capture.
- States:
  - IDLE: decode_valid=0. On capture, go to VALID and latch all outputs.
  - VALID: decode_valid=1 and outputs are stable while decode_ready=0.
    - decode_ready=1 with capture: stay in VALID and load the new instruction (back-to-back).
    - decode_ready=1 without capture: go to IDLE.
- Flush has priority over everything:
  - Next state is IDLE and decode_valid=0 next cycle.
  - If the capture condition also holds that cycle, fetch_ack is still pulsed so the fetcher is released, but the word is discarded (decode_valid stays 0).
- Immediate by opcode, always sign-extended from instr[31] to ADDR_W:
  - I-type (0000011, 0010011, 0011011, 1100111, 1110011): instr[31:20]
  - S-type (0100011): {instr[31:25], instr[11:7]}
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All other opcodes (0110011, 0111011, 0001111): imm=0.
- illegal=1 when opcode is not in the 13 listed opcodes (this includes instr[1:0]≠11). An illegal instruction is still presented with decode_valid=1; fields are decoded as-is and imm=0.
- Reset mid-operation: outputs clear immediately. An in-flight fetcher handshake is abandoned; the fetcher is reset by the same reset.

Test Plan:
- Word 0x00000000_00500093, address 0x1000, fetcher_done=1 → fetch_ack pulses 1 cycle; next cycle decode_valid=1, pc_out=0x1000, opcode=0x13, rd=1, rs1=0, imm=5, illegal=0.
- Word 0xFE000EE3_00000013, address 0x2004 → upper half selected: opcode=0x63, funct3=0, imm=0xFFFFFFFFFFFFFFFC.
- 0x800002B7 (low half) → rd=5, imm=0xFFFFFFFF80000000. Hold decode_ready=0 for 5 cycles → outputs stable. Keep fetcher_done=1 through the ack cycle → exactly one fetch_ack pulse.
- decode_ready=1 while fetcher_done=1 (ack low) in VALID → new instruction loaded next cycle, decode_valid stays 1 with no bubble.
- flush=1 in the same cycle as fetcher_done=1 → fetch_ack pulses, decode_valid=0 next cycle. flush=1 in VALID → decode_valid=0 next cycle.
- Instruction 0x0000007F → illegal=1, imm=0. Assert reset=0 asynchronously mid-VALID → decode_valid and fetch_ack drop to 0 before the next clock edge.
